// File: rtl/boot_loader.sv
`default_nettype none
// ============================================================================
// Module   : boot_loader
// Brief    : Byte-stream image loader for instruction/data memories; holds the
//            core in reset until the end-of-image command arrives.
//            Define BOOT_LOADER_CHECKSUM_EN for a per-section XOR checksum byte.
// Revision : 1.0 - initial release
// ============================================================================
module boot_loader #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [7:0]        in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic              wr_en,
    output logic              wr_sel,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [DATA_W-1:0] wr_data,
    output logic              core_reset,
    output logic              done,
    output logic              err
);

    localparam logic [7:0] c_cmd_instr = 8'h01;
    localparam logic [7:0] c_cmd_data  = 8'h02;
    localparam logic [7:0] c_cmd_end   = 8'hFF;

    typedef enum logic [3:0] {
        S_CMD     = 4'd0,
        S_ADDR_HI = 4'd1,
        S_ADDR_LO = 4'd2,
        S_CNT_HI  = 4'd3,
        S_CNT_LO  = 4'd4,
        S_DATA_HI = 4'd5,
        S_DATA_LO = 4'd6,
        S_DONE    = 4'd7,
`ifdef BOOT_LOADER_CHECKSUM_EN
        S_CSUM    = 4'd9,
`endif
        S_ERR     = 4'd8
    } state_t;

    state_t            r_state,   w_state;
    logic [7:0]        r_ahi,     w_ahi;
    logic [ADDR_W-1:0] r_addr,    w_addr;
    logic [15:0]       r_cnt,     w_cnt;
    logic [7:0]        r_hi,      w_hi;
    logic              r_sel,     w_sel;
    logic              r_wr_en,   w_wr_en;
    logic              r_wr_sel,  w_wr_sel;
    logic [ADDR_W-1:0] r_wr_addr, w_wr_addr;
    logic [DATA_W-1:0] r_wr_data, w_wr_data;
    logic [15:0]       w_cnt_dec;
    logic              w_accept;
`ifdef BOOT_LOADER_CHECKSUM_EN
    logic [7:0]        r_csum,    w_csum;
`endif

    always_comb begin
        w_state   = r_state;
        w_ahi     = r_ahi;
        w_addr    = r_addr;
        w_cnt     = r_cnt;
        w_hi      = r_hi;
        w_sel     = r_sel;
        w_wr_en   = 1'b0;
        w_wr_sel  = r_wr_sel;
        w_wr_addr = r_wr_addr;
        w_wr_data = r_wr_data;
        w_cnt_dec = r_cnt - 16'd1;
        w_accept  = in_valid && in_ready;
`ifdef BOOT_LOADER_CHECKSUM_EN
        w_csum    = r_csum;
        if (w_accept) begin
            w_csum = (r_state == S_CMD) ? in_data : (r_csum ^ in_data);
        end
`endif
        if (w_accept) begin
            case (r_state)
                S_CMD: begin
                    if (in_data == c_cmd_instr || in_data == c_cmd_data) begin
                        w_sel   = (in_data == c_cmd_data);
                        w_state = S_ADDR_HI;
                    end else if (in_data == c_cmd_end) begin
                        w_state = S_DONE;
                    end else begin
                        w_state = S_ERR;
                    end
                end
                S_ADDR_HI: begin
                    w_ahi   = in_data;
                    w_state = S_ADDR_LO;
                end
                S_ADDR_LO: begin
                    // Upper received address bits beyond ADDR_W are dropped here
                    w_addr  = ADDR_W'({r_ahi, in_data});
                    w_state = S_CNT_HI;
                end
                S_CNT_HI: begin
                    w_cnt[15:8] = in_data;
                    w_state     = S_CNT_LO;
                end
                S_CNT_LO: begin
                    w_cnt   = {r_cnt[15:8], in_data};
                    w_state = ({r_cnt[15:8], in_data} == 16'd0) ? S_CMD : S_DATA_HI;
                end
                S_DATA_HI: begin
                    w_hi    = in_data;
                    w_state = S_DATA_LO;
                end
                S_DATA_LO: begin
                    w_wr_en   = 1'b1;
                    w_wr_sel  = r_sel;
                    w_wr_addr = r_addr;
                    w_wr_data = {r_hi, in_data};
                    w_addr    = r_addr + ADDR_W'(1);
                    w_cnt     = w_cnt_dec;
                    if (w_cnt_dec != 16'd0) begin
                        w_state = S_DATA_HI;
                    end else begin
`ifdef BOOT_LOADER_CHECKSUM_EN
                        w_state = S_CSUM;
`else
                        w_state = S_CMD;
`endif
                    end
                end
`ifdef BOOT_LOADER_CHECKSUM_EN
                S_CSUM: begin
                    w_state = (in_data == r_csum) ? S_CMD : S_ERR;
                end
`endif
                default: begin
                    w_state = r_state;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state   <= S_CMD;
            r_ahi     <= 8'd0;
            r_addr    <= '0;
            r_cnt     <= 16'd0;
            r_hi      <= 8'd0;
            r_sel     <= 1'b0;
            r_wr_en   <= 1'b0;
            r_wr_sel  <= 1'b0;
            r_wr_addr <= '0;
            r_wr_data <= '0;
`ifdef BOOT_LOADER_CHECKSUM_EN
            r_csum    <= 8'd0;
`endif
        end else begin
            r_state   <= w_state;
            r_ahi     <= w_ahi;
            r_addr    <= w_addr;
            r_cnt     <= w_cnt;
            r_hi      <= w_hi;
            r_sel     <= w_sel;
            r_wr_en   <= w_wr_en;
            r_wr_sel  <= w_wr_sel;
            r_wr_addr <= w_wr_addr;
            r_wr_data <= w_wr_data;
`ifdef BOOT_LOADER_CHECKSUM_EN
            r_csum    <= w_csum;
`endif
        end
    end

    assign in_ready   = (r_state != S_DONE) && (r_state != S_ERR);
    assign core_reset = (r_state != S_DONE);
    assign done       = (r_state == S_DONE);
    assign err        = (r_state == S_ERR);
    assign wr_en      = r_wr_en;
    assign wr_sel     = r_wr_sel;
    assign wr_addr    = r_wr_addr;
    assign wr_data    = r_wr_data;

endmodule
`default_nettype wire

// File: doc/boot_loader.md
Name: boot_loader

Overview:
- Byte-stream loader that fills the CPU's instruction and data memories before execution, then releases the core from reset.
- It is the writer for the post-halt memory readout: benches and FPGA UART glue push a program image through it instead of using $readmemb.
- Sits between the host byte source and the memory write ports in top, and drives the core's reset.

Parameters:
- ADDR_W, 10, word-address width of each memory; the upper address bits received are discarded.
- DATA_W, 16, memory word width. Fixed at 16 and carried as two bytes, high byte first.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-low reset
- in_data  in  8  stream byte
- in_valid  in  1  in_data valid
- in_ready  out  1  loader accepts a byte this cycle
- wr_en  out  1  one-cycle memory write strobe
- wr_sel  out  1  0 = instruction memory, 1 = data memory
- wr_addr  out  ADDR_W  word address
- wr_data  out  16  word to write
- core_reset  out  1  active-high reset to the core; held while loading
- done  out  1  image loaded and core released
- err  out  1  protocol error; sticky

Behaviour:
- A byte is accepted on a rising clk edge when in_valid and in_ready are both 1. in_data is sampled only on accepted edges.
- Stream format:
  - Section: CMD byte, ADDR_HI, ADDR_LO, CNT_HI, CNT_LO, then CNT words, each sent as hi byte then lo byte.
  - CMD 0x01 selects the instruction section; CMD 0x02 selects the data section.
  - CMD 0xFF ends the image.
  - Any other CMD value is an error.
- States: CMD, ADDR_HI, ADDR_LO, CNT_HI, CNT_LO, DATA_HI, DATA_LO, DONE, ERR.
  - CMD:
    - 0x01 or 0x02 latches wr_sel and goes to ADDR_HI.
    - 0xFF goes to DONE.
    - Any other value goes to ERR.
  - ADDR_HI to ADDR_LO to CNT_HI to CNT_LO. Address and count are each 16 bits.
  - CNT_LO:
    - Count 0 goes to CMD with no writes.
    - Otherwise goes to DATA_HI.
  - DATA_HI: latches the high byte.
  - DATA_LO:
    - Registers the write.
    - Decrements the remaining count.
    - Goes to DATA_HI while count > 0 after the decrement, otherwise to CMD.
  - DONE and ERR are terminal until reset.
- in_ready = 1 in every state except DONE and ERR.
- Write timing: when the DATA_LO byte is accepted at edge N, wr_en is 1 for exactly the cycle after edge N. In that cycle:
  - wr_addr = current address,
  - wr_data = {hi, lo},
  - wr_sel = the latched section select.
- The address increments by 1 after each write. It wraps modulo 2^ADDR_W, i.e. 2^ADDR_W-1 is followed by 0.
- Outside write cycles, wr_en = 0 and wr_addr, wr_data and wr_sel hold their last values.
- core_reset:
  - 1 from reset until DONE is entered.
  - Falls to 0 in the cycle after the 0xFF byte is accepted; done rises in the same cycle.
  - Stays 1 forever in ERR.
- err rises in the cycle after the offending byte is accepted.
- Reset (reset == 0 at a clk edge), including mid-section:
  - State returns to CMD; address and count are cleared.
  - Outputs: wr_en=0, wr_sel=0, wr_addr=0, wr_data=0, in_ready=1, core_reset=1, done=0, err=0.
  - A partially received word is never written.
- Back-to-back bytes, one per cycle, are accepted with no bubbles. in_valid gaps of any length are tolerated in every state.

Optional Feature:
- BOOT_LOADER_CHECKSUM_EN defined:
  - Each non-empty section carries one extra byte after its last data byte: the XOR of every byte of the section from CMD through the last data byte.
  - This adds a CSUM state that returns to CMD on a match and goes to ERR on a mismatch.
  - Sections with count 0 carry no checksum byte.
  - All words of the section are still written before the check.
- Not defined: there is no CSUM state and sections end after their last data byte.

Test Plan:
- Reset, then send 01 00 00 00 02 E0 00 12 34, then FF -> writes instr[0]=0xE000 and instr[1]=0x1234 on the cycles after their lo bytes; core_reset falls the cycle after FF; done=1.
- Send 02 00 01 00 01 AB CD, then FF -> exactly one wr_en pulse with wr_sel=1, wr_addr=1, wr_data=0xABCD; err=0.
- With ADDR_W=10, send 01 03 FF 00 02 then 4 data bytes -> writes at addresses 0x3FF then 0x000.
- Send 01 00 00 00 00 then 07 -> no writes; err=1 the cycle after 07; in_ready=0; core_reset stays 1.
- Hold reset low after the DATA_HI byte of a section, then restart with a fresh image -> no stray write; all outputs at reset values; the new image loads correctly.
- CHECKSUM_EN: send 01 00 00 00 01 11 22 with checksum 0x33 -> section accepted; the same section with checksum 0x34 -> err=1 after the write to instr[0].
